// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter for the shared ROM/RAM bus with address decode and fixed-latency ack.
// Optional ARB_LOCK_EN adds lock0/lock1 so a master can keep the bus across back-to-back transactions.
module mem_bus_arbiter #(
  parameter int AW          = 8,
  parameter int DW          = 8,
  parameter int WAIT_STATES = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] adrs0,
  input  logic [DW-1:0] wdata0,
  output logic          ack0,
  output logic          err0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] adrs1,
  input  logic [DW-1:0] wdata1,
  output logic          ack1,
  output logic          err1,
  output logic [DW-1:0] rdata1,
  output logic [AW-1:0] adrs,
  output logic [DW-1:0] dout,
  input  logic [DW-1:0] din,
  output logic          mem_read,
  output logic          mem_write,
  output logic          rom_cs,
  output logic          ram_cs
`ifdef ARB_LOCK_EN
  ,
  input  logic          lock0,
  input  logic          lock1
`endif
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [2:0] LAST_WAIT = 3'(WAIT_STATES);

  state_t     state;
  logic       last_grant;
  logic       gnt;
  logic       g_we;
  logic       g_err;
  logic [2:0] wcnt;
  logic       mem_write_q;

  logic          pick_valid;
  logic          pick;
  logic          sel_we;
  logic [AW-1:0] sel_adrs;
  logic [DW-1:0] sel_wdata;
  logic          sel_rom;
  logic          sel_ram;
  logic          sel_err;

`ifdef ARB_LOCK_EN
  logic lock_hold;
  logic lock_owner;
`endif

  always_comb begin
    pick_valid = req0 | req1;
    pick       = (req0 & req1) ? ~last_grant : req1;
`ifdef ARB_LOCK_EN
    if (lock_hold && (lock_owner ? req1 : req0))
      pick = lock_owner;
`endif
    sel_we    = pick ? we1 : we0;
    sel_adrs  = pick ? adrs1 : adrs0;
    sel_wdata = pick ? wdata1 : wdata0;
    sel_rom   = (sel_adrs[7:5] == 3'b000);
    sel_ram   = (sel_adrs[7:2] == 6'b001000);
    sel_err   = sel_we ? ~sel_ram : ~(sel_rom | sel_ram);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      gnt         <= 1'b0;
      g_we        <= 1'b0;
      g_err       <= 1'b0;
      wcnt        <= '0;
      ack0        <= 1'b0;
      ack1        <= 1'b0;
      err0        <= 1'b0;
      err1        <= 1'b0;
      rdata0      <= '0;
      rdata1      <= '0;
      adrs        <= '0;
      dout        <= '0;
      mem_read    <= 1'b0;
      mem_write_q <= 1'b0;
`ifdef ARB_LOCK_EN
      lock_hold   <= 1'b0;
      lock_owner  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          adrs <= '1;
`ifdef ARB_LOCK_EN
          if (lock_hold && !(lock_owner ? req1 : req0))
            lock_hold <= 1'b0;
`endif
          if (pick_valid) begin
            gnt         <= pick;
            last_grant  <= pick;
            g_we        <= sel_we;
            g_err       <= sel_err;
            adrs        <= sel_adrs;
            dout        <= sel_wdata;
            mem_read    <= ~sel_we & ~sel_err;
            mem_write_q <= sel_we & ~sel_err;
            wcnt        <= '0;
            state       <= ACCESS;
          end
        end
        ACCESS: begin
          if (wcnt == LAST_WAIT) begin
            mem_read    <= 1'b0;
            mem_write_q <= 1'b0;
            adrs        <= '1;
            // Writes leave rdata alone; errors of either kind clear it.
            if (gnt) begin
              ack1 <= 1'b1;
              err1 <= g_err;
              if (g_err)      rdata1 <= '0;
              else if (!g_we) rdata1 <= din;
            end else begin
              ack0 <= 1'b1;
              err0 <= g_err;
              if (g_err)      rdata0 <= '0;
              else if (!g_we) rdata0 <= din;
            end
            state <= RESP;
          end else begin
            wcnt <= wcnt + 3'd1;
          end
        end
        RESP: begin
          ack0  <= 1'b0;
          ack1  <= 1'b0;
          err0  <= 1'b0;
          err1  <= 1'b0;
`ifdef ARB_LOCK_EN
          lock_hold  <= gnt ? lock1 : lock0;
          lock_owner <= gnt;
`endif
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Reset is synchronous, so a strobe registered before it must be masked in the reset cycle itself.
  assign mem_write = mem_write_q & ~rst;
  assign rom_cs    = (adrs[7:5] == 3'b000);
  assign ram_cs    = (adrs[7:2] == 6'b001000);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: one instance with no wait states, one with two.
// Expected results come from a transaction-level model of the decode, memory and arbitration rules.
module tb_mem_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst       [2];
  logic       req0      [2];
  logic       we0       [2];
  logic [7:0] adrs0     [2];
  logic [7:0] wdata0    [2];
  logic       ack0      [2];
  logic       err0      [2];
  logic [7:0] rdata0    [2];
  logic       req1      [2];
  logic       we1       [2];
  logic [7:0] adrs1     [2];
  logic [7:0] wdata1    [2];
  logic       ack1      [2];
  logic       err1      [2];
  logic [7:0] rdata1    [2];
  logic [7:0] adrs      [2];
  logic [7:0] dout      [2];
  logic [7:0] din       [2];
  logic       mem_read  [2];
  logic       mem_write [2];
  logic       rom_cs    [2];
  logic       ram_cs    [2];

  logic [7:0] env_ram [2][4] = '{default: 8'h00};
  logic [7:0] mdl_ram [2][4];
  logic [7:0] mdl_rd  [2][2];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.AW(8), .DW(8), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .rst(rst[0]),
    .req0(req0[0]), .we0(we0[0]), .adrs0(adrs0[0]), .wdata0(wdata0[0]),
    .ack0(ack0[0]), .err0(err0[0]), .rdata0(rdata0[0]),
    .req1(req1[0]), .we1(we1[0]), .adrs1(adrs1[0]), .wdata1(wdata1[0]),
    .ack1(ack1[0]), .err1(err1[0]), .rdata1(rdata1[0]),
    .adrs(adrs[0]), .dout(dout[0]), .din(din[0]),
    .mem_read(mem_read[0]), .mem_write(mem_write[0]),
    .rom_cs(rom_cs[0]), .ram_cs(ram_cs[0])
`ifdef ARB_LOCK_EN
    , .lock0(1'b0), .lock1(1'b0)
`endif
  );

  mem_bus_arbiter #(.AW(8), .DW(8), .WAIT_STATES(2)) u_dut1 (
    .clk(clk), .rst(rst[1]),
    .req0(req0[1]), .we0(we0[1]), .adrs0(adrs0[1]), .wdata0(wdata0[1]),
    .ack0(ack0[1]), .err0(err0[1]), .rdata0(rdata0[1]),
    .req1(req1[1]), .we1(we1[1]), .adrs1(adrs1[1]), .wdata1(wdata1[1]),
    .ack1(ack1[1]), .err1(err1[1]), .rdata1(rdata1[1]),
    .adrs(adrs[1]), .dout(dout[1]), .din(din[1]),
    .mem_read(mem_read[1]), .mem_write(mem_write[1]),
    .rom_cs(rom_cs[1]), .ram_cs(ram_cs[1])
`ifdef ARB_LOCK_EN
    , .lock0(1'b0), .lock1(1'b0)
`endif
  );

  function automatic logic [7:0] rom_val(input logic [4:0] a);
    if (a == 5'd5) return 8'h3C;
    return 8'({3'b000, a} * 8'd29 + 8'd11);
  endfunction

  // Memory behind each bus: ROM contents are fixed, RAM is written by the DUT's strobes.
  always_comb begin
    din[0] = 8'h00;
    if (rom_cs[0])      din[0] = rom_val(adrs[0][4:0]);
    else if (ram_cs[0]) din[0] = env_ram[0][adrs[0][1:0]];
  end
  always_comb begin
    din[1] = 8'h00;
    if (rom_cs[1])      din[1] = rom_val(adrs[1][4:0]);
    else if (ram_cs[1]) din[1] = env_ram[1][adrs[1][1:0]];
  end
  always @(posedge clk) if (mem_write[0] && ram_cs[0]) env_ram[0][adrs[0][1:0]] <= dout[0];
  always @(posedge clk) if (mem_write[1] && ram_cs[1]) env_ram[1][adrs[1][1:0]] <= dout[1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  function automatic logic model_err(input logic w, input logic [7:0] a);
    return (a >= 8'h24) || (w && a < 8'h20);
  endfunction

  function automatic logic [7:0] model_read(input int d, input logic [7:0] a);
    return (a < 8'h20) ? rom_val(a[4:0]) : mdl_ram[d][a[1:0]];
  endfunction

  // Runs one transaction from an IDLE cycle and returns in the following IDLE cycle.
  task automatic txn(input int d, input int m, input logic w, input logic [7:0] a, input logic [7:0] wd);
    int ws, lat, rdc, wrc, csbad, other;
    logic e;
    logic [7:0] er;
    bit got;
    ws = (d == 0) ? 0 : 2;
    e  = model_err(w, a);
    if (e)       er = 8'h00;
    else if (!w) er = model_read(d, a);
    else         er = mdl_rd[d][m];
    if (m == 0) begin req0[d] = 1'b1; we0[d] = w; adrs0[d] = a; wdata0[d] = wd; end
    else        begin req1[d] = 1'b1; we1[d] = w; adrs1[d] = a; wdata1[d] = wd; end
    got = 0; lat = -1; rdc = 0; wrc = 0; csbad = 0; other = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (mem_read[d])  rdc++;
      if (mem_write[d]) wrc++;
      if ((mem_read[d] || mem_write[d]) &&
          (rom_cs[d] !== (a < 8'h20) || ram_cs[d] !== (a[7:2] == 6'b001000))) csbad++;
      if (m == 0 ? ack1[d] : ack0[d]) other++;
      if (m == 0 ? ack0[d] : ack1[d]) begin got = 1; lat = k; end
    end
    chk("ack_seen", 32'(got), 32'd1);
    chk("latency", 32'(lat), 32'(2 + ws));
    chk("err", 32'(m == 0 ? err0[d] : err1[d]), 32'(e));
    chk("rdata", 32'(m == 0 ? rdata0[d] : rdata1[d]), 32'(er));
    chk("rd_strobes", 32'(rdc), 32'((!e && !w) ? 1 + ws : 0));
    chk("wr_strobes", 32'(wrc), 32'((!e && w) ? 1 + ws : 0));
    chk("cs_decode", 32'(csbad), 32'd0);
    chk("other_ack", 32'(other), 32'd0);
    mdl_rd[d][m] = er;
    if (!e && w) mdl_ram[d][a[1:0]] = wd;
    @(posedge clk); #1;
    if (m == 0) req0[d] = 1'b0; else req1[d] = 1'b0;
  endtask

  initial begin
    logic [7:0] ra;
    logic       rw;
    int         rd, rm, sel;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1;
      req0[d] = 1'b0; we0[d] = 1'b0; adrs0[d] = 8'h00; wdata0[d] = 8'h00;
      req1[d] = 1'b0; we1[d] = 1'b0; adrs1[d] = 8'h00; wdata1[d] = 8'h00;
      for (int i = 0; i < 4; i++) mdl_ram[d][i] = 8'h00;
      mdl_rd[d][0] = 8'h00; mdl_rd[d][1] = 8'h00;
    end
    // Both masters request reads on instance 0 continuously from reset.
    req0[0] = 1'b1; adrs0[0] = 8'h05;
    req1[0] = 1'b1; adrs1[0] = 8'h21;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_ack0", 32'(ack0[d]), 32'd0);
      chk("rst_ack1", 32'(ack1[d]), 32'd0);
      chk("rst_err", 32'({err0[d], err1[d]}), 32'd0);
      chk("rst_rdata0", 32'(rdata0[d]), 32'h00);
      chk("rst_rdata1", 32'(rdata1[d]), 32'h00);
      chk("rst_adrs", 32'(adrs[d]), 32'h00);
      chk("rst_dout", 32'(dout[d]), 32'h00);
      chk("rst_strobes", 32'({mem_read[d], mem_write[d]}), 32'd0);
    end
    @(posedge clk); #1;
    rst[0] = 1'b0; rst[1] = 1'b0;

    // Round robin from reset: master 0 first, one ack every 3 cycles, strictly alternating.
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("rr_ack0", 32'(ack0[0]), 32'((k % 3 == 2) && ((k / 3) % 2 == 0)));
      chk("rr_ack1", 32'(ack1[0]), 32'((k % 3 == 2) && ((k / 3) % 2 == 1)));
      if (k % 3 == 2) begin
        if ((k / 3) % 2 == 0) chk("rr_rdata0", 32'(rdata0[0]), 32'(model_read(0, 8'h05)));
        else                  chk("rr_rdata1", 32'(rdata1[0]), 32'(model_read(0, 8'h21)));
      end
    end
    mdl_rd[0][0] = model_read(0, 8'h05);
    mdl_rd[0][1] = model_read(0, 8'h21);
    @(posedge clk); #1;
    req0[0] = 1'b0; req1[0] = 1'b0;
    @(posedge clk); #1;

    txn(0, 0, 1'b0, 8'h05, 8'h00);
    chk("rom_0x05", 32'(rdata0[0]), 32'h3C);
    @(negedge clk);
    chk("idle_adrs", 32'(adrs[0]), 32'hFF);
    chk("idle_cs", 32'({rom_cs[0], ram_cs[0]}), 32'd0);
    @(posedge clk); #1;
    txn(0, 1, 1'b1, 8'h22, 8'hA5);
    txn(0, 1, 1'b0, 8'h22, 8'h00);
    chk("ram_0x22", 32'(rdata1[0]), 32'hA5);
    txn(0, 0, 1'b1, 8'h10, 8'h5A);
    txn(0, 0, 1'b0, 8'h80, 8'h00);
    txn(1, 0, 1'b0, 8'h21, 8'h00);

    // Reset during the ACCESS cycle of a RAM write aborts it.
    req0[0] = 1'b1; we0[0] = 1'b1; adrs0[0] = 8'h20; wdata0[0] = 8'h77;
    @(posedge clk); #1;
    rst[0] = 1'b1;
    @(negedge clk);
    chk("abort_no_write", 32'(mem_write[0]), 32'd0);
    @(negedge clk);
    chk("abort_ack", 32'({ack0[0], ack1[0]}), 32'd0);
    chk("abort_adrs", 32'(adrs[0]), 32'h00);
    chk("abort_strobes", 32'({mem_read[0], mem_write[0]}), 32'd0);
    chk("abort_rdata", 32'({rdata0[0], rdata1[0]}), 32'h0000);
    chk("abort_ram", 32'(env_ram[0][0]), 32'(mdl_ram[0][0]));
    mdl_rd[0][0] = 8'h00; mdl_rd[0][1] = 8'h00;
    @(posedge clk); #1;
    rst[0] = 1'b0; req0[0] = 1'b0; we0[0] = 1'b0;
    txn(0, 0, 1'b0, 8'h20, 8'h00);

    for (int i = 0; i < 40; i++) begin
      rd  = int'($urandom_range(1, 0));
      rm  = int'($urandom_range(1, 0));
      rw  = 1'($urandom_range(1, 0));
      sel = int'($urandom_range(3, 0));
      if (sel == 0)      ra = 8'($urandom_range(31, 0));
      else if (sel == 3) ra = 8'($urandom_range(255, 0));
      else               ra = 8'($urandom_range(35, 32));
      repeat ($urandom_range(2, 0)) @(posedge clk);
      #1;
      txn(rd, rm, rw, ra, 8'($urandom_range(255, 0)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
